// File: rtl/bridge_dt_pkg.sv
// rtl/bridge_dt_pkg.sv - shared types and request decode for the bridge dead-time generator
package bridge_dt_pkg;

    typedef enum logic [1:0] {
        PH_OFF = 2'd0,
        PH_HI  = 2'd1,
        PH_LO  = 2'd2
    } phase_state_t;

    // Bit offsets of the high and low switch within one phase pair
    localparam int HI_BIT = 0;
    localparam int LO_BIT = 1;

    typedef enum logic [1:0] {
        REQ_OFF     = 2'd0,
        REQ_HI      = 2'd1,
        REQ_LO      = 2'd2,
        REQ_ILLEGAL = 2'd3
    } phase_req_t;

    // Both switches requested together is never honoured
    function automatic phase_req_t decode_req(input logic [1:0] pair);
        case ({pair[LO_BIT], pair[HI_BIT]})
            2'b00:   decode_req = REQ_OFF;
            2'b01:   decode_req = REQ_HI;
            2'b10:   decode_req = REQ_LO;
            default: decode_req = REQ_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/bridge_dt_phase.sv
// rtl/bridge_dt_phase.sv - one half-bridge phase: FSM, dead counter, optional min-on (HAMSTER_BRIDGE_MIN_ON_EN)
module bridge_dt_phase
    import bridge_dt_pkg::*;
#(
    parameter int K_DTRES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         pair,
    input  logic               enable,
    input  logic [K_DTRES-1:0] dead_time,
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
    input  logic [K_DTRES-1:0] min_on,
`endif
    output logic [1:0]         cmd,
    output logic               dead,
    output logic               illegal
);

    localparam logic [K_DTRES-1:0] CNT_MAX = '1;

    phase_state_t       state, state_nxt;
    phase_req_t         req;
    logic [K_DTRES-1:0] cnt, cnt_nxt;
    logic               dead_nxt;
    logic               want_on;
    logic               leave_ok;
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
    logic [K_DTRES-1:0] on_cnt, on_nxt;
`endif

    // State, dead counter and the registered dead-hold flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PH_OFF;
            cnt    <= '0;
            dead   <= 1'b0;
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
            on_cnt <= '0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dead   <= dead_nxt;
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
            on_cnt <= on_nxt;
`endif
        end
    end

    // Next state: every switch-over goes through OFF and waits out the dead time there
    always_comb begin
        req       = decode_req(pair);
        want_on   = (req == REQ_HI) || (req == REQ_LO);
        illegal   = (req == REQ_ILLEGAL);
        state_nxt = state;
        cnt_nxt   = cnt;
        dead_nxt  = (state == PH_OFF) && want_on && enable && (cnt < dead_time);
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
        on_nxt    = on_cnt;
        // Disable and illegal requests bypass the minimum on-time
        leave_ok  = !enable || illegal || (on_cnt >= min_on);
`else
        leave_ok  = 1'b1;
`endif
        case (state)
            PH_OFF: begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                if (want_on && enable && (cnt >= dead_time)) begin
                    state_nxt = (req == REQ_HI) ? PH_HI : PH_LO;
                    cnt_nxt   = '0;
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
                    on_nxt    = '0;
`endif
                end
            end
            PH_HI, PH_LO: begin
                cnt_nxt = '0;
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
                on_nxt  = (on_cnt == CNT_MAX) ? on_cnt : on_cnt + 1'b1;
`endif
                if ((!enable || req != ((state == PH_HI) ? REQ_HI : REQ_LO)) && leave_ok) begin
                    state_nxt = PH_OFF;
                end
            end
            default: begin
                state_nxt = PH_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pin drive decoded straight from the registered state
    always_comb begin
        cmd         = 2'b00;
        cmd[HI_BIT] = (state == PH_HI);
        cmd[LO_BIT] = (state == PH_LO);
    end

endmodule

// File: rtl/bridge_deadtime_gen.sv
// rtl/bridge_deadtime_gen.sv - per-motor dead-time output stage; optional min-on via HAMSTER_BRIDGE_MIN_ON_EN
module bridge_deadtime_gen
    import bridge_dt_pkg::*;
#(
    parameter int K_NPHASE = 3,
    parameter int K_DTRES  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [2*K_NPHASE-1:0] i_cmd,
    input  logic                  i_enable,
    input  logic [K_DTRES-1:0]    i_dead_time,
    input  logic [K_DTRES-1:0]    i_min_on,
    input  logic                  i_fault_clr,
    output logic [2*K_NPHASE-1:0] o_cmd,
    output logic [K_NPHASE-1:0]   o_dead,
    output logic                  o_fault
);

    logic [K_NPHASE-1:0] illegal;

    for (genvar k = 0; k < K_NPHASE; k++) begin : g_phase
        bridge_dt_phase #(
            .K_DTRES (K_DTRES)
        ) u_phase (
            .clk       (i_clk),
            .rst_n     (i_rst_n),
            .pair      (i_cmd[2*k+1:2*k]),
            .enable    (i_enable),
            .dead_time (i_dead_time),
`ifdef HAMSTER_BRIDGE_MIN_ON_EN
            .min_on    (i_min_on),
`endif
            .cmd       (o_cmd[2*k+1:2*k]),
            .dead      (o_dead[k]),
            .illegal   (illegal[k])
        );
    end

`ifndef HAMSTER_BRIDGE_MIN_ON_EN
    logic unused_min_on;
    assign unused_min_on = ^i_min_on;
`endif

    // Sticky shoot-through flag; a new illegal request outranks a clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fault <= 1'b0;
        end else if (|illegal) begin
            o_fault <= 1'b1;
        end else if (i_fault_clr) begin
            o_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bridge_deadtime_gen.sv
// tb/tb_bridge_deadtime_gen.sv - self-checking bench for bridge_deadtime_gen
module tb_bridge_deadtime_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] cmd = '0;
    logic       en = 1'b0;
    logic [7:0] dt = '0;
    logic [7:0] mo = '0;
    logic       clr = 1'b0;
    logic       running = 1'b0;
    logic [5:0] o_cmd;
    logic [2:0] o_dead;
    logic       o_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bridge_deadtime_gen #(.K_NPHASE(3), .K_DTRES(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd       (cmd),
        .i_enable    (en),
        .i_dead_time (dt),
        .i_min_on    (mo),
        .i_fault_clr (clr),
        .o_cmd       (o_cmd),
        .o_dead      (o_dead),
        .o_fault     (o_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each phase is off/hi/lo plus "cycles spent off so far"
    int         m_mode [3] = '{0, 0, 0};
    int         m_age  [3] = '{0, 0, 0};
    logic [5:0] e_cmd   = '0;
    logic [2:0] e_dead  = '0;
    logic       e_fault = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int r, mode, age;
        logic ill;
        logic [5:0] nc;
        logic [2:0] nd;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_mode[k] <= 0;
                m_age[k]  <= 0;
            end
            e_cmd   <= '0;
            e_dead  <= '0;
            e_fault <= 1'b0;
        end else begin
            ill = 1'b0;
            nc  = '0;
            nd  = '0;
            for (int k = 0; k < 3; k++) begin
                r    = int'(cmd[2*k +: 2]);
                mode = m_mode[k];
                age  = m_age[k];
                if (r == 3) ill = 1'b1;
                nd[k] = (mode == 0) && (r == 1 || r == 2) && en && (age < int'(dt));
                if (mode == 0) begin
                    if ((r == 1 || r == 2) && en && age >= int'(dt)) begin
                        mode = r;
                        age  = 0;
                    end else if (age < 255) begin
                        age = age + 1;
                    end
                end else if (!en || r != mode) begin
                    mode = 0;
                    age  = 0;
                end
                nc[2*k +: 2] = (mode == 1) ? 2'b01 : (mode == 2) ? 2'b10 : 2'b00;
                m_mode[k] <= mode;
                m_age[k]  <= age;
            end
            e_cmd   <= nc;
            e_dead  <= nd;
            e_fault <= ill ? 1'b1 : (clr ? 1'b0 : e_fault);
        end
    end

    // Per-cycle comparison against the model, plus the no-shoot-through rule
    always @(posedge clk) begin
        #2;
        if (running && rst_n) begin
            check("cyc_cmd", o_cmd, e_cmd);
            check("cyc_dead", o_dead, e_dead);
            check("cyc_fault", o_fault, e_fault);
            for (int k = 0; k < 3; k++)
                check("no_shoot", (o_cmd[2*k +: 2] == 2'b11), 0);
        end
    end

    logic [5:0] v_cmd  [10] = '{6'b000000, 6'b010101, 6'b101010, 6'b010110, 6'b111111,
                                6'b011010, 6'b011010, 6'b100101, 6'b000101, 6'b101001};
    logic       v_en   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] v_dt   [10] = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd5, 8'd1, 8'd1, 8'd255, 8'd7, 8'd2};
    int         v_hold [10] = '{2, 3, 3, 9, 2, 3, 4, 6, 12, 6};

    initial begin
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_cmd", o_cmd, 6'b000000);
        check("rst_dead", o_dead, 3'b000);
        check("rst_fault", o_fault, 1'b0);

        // Turn-on from reset waits the full dead time
        en = 1'b1; dt = 8'd4; cmd = 6'b000001; rst_n = 1'b1; running = 1'b1;
        tick(4);
        check("t1_wait_cmd", o_cmd, 6'b000000);
        check("t1_wait_dead", o_dead, 3'b001);
        tick(1);
        check("t1_on_cmd", o_cmd, 6'b000001);
        check("t1_on_dead", o_dead, 3'b000);

        // HI -> LO passes through D+1 all-off cycles
        dt = 8'd3; cmd = 6'b000010;
        tick(1);
        check("t2_off1", o_cmd, 6'b000000);
        tick(3);
        check("t2_off4", o_cmd, 6'b000000);
        tick(1);
        check("t2_lo", o_cmd, 6'b000010);

        // Illegal request, sticky fault, clear, set-beats-clear
        cmd = 6'b001110;
        tick(1);
        check("t3_cmd", o_cmd, 6'b000010);
        check("t3_fault_set", o_fault, 1'b1);
        cmd = 6'b000010;
        tick(3);
        check("t3_fault_sticky", o_fault, 1'b1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t3_fault_clr", o_fault, 1'b0);
        cmd = 6'b001110; clr = 1'b1;
        tick(1);
        cmd = 6'b000010; clr = 1'b0;
        check("t3_set_wins", o_fault, 1'b1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;

        // Disable forces all off; re-enable waits D+1 off cycles
        cmd = 6'b011001;
        tick(8);
        check("t4_all_on", o_cmd, 6'b011001);
        en = 1'b0;
        tick(1);
        check("t4_disabled", o_cmd, 6'b000000);
        en = 1'b1; dt = 8'd2;
        tick(2);
        check("t4_still_off", o_cmd, 6'b000000);
        tick(1);
        check("t4_reon", o_cmd, 6'b011001);

        // Live dead-time change mid-count
        dt = 8'd10; cmd = 6'b001001;
        tick(1);
        check("t5_p2_off", o_cmd, 6'b001001);
        cmd = 6'b011001;
        tick(5);
        check("t5_waiting_cmd", o_cmd, 6'b001001);
        check("t5_waiting_dead", o_dead, 3'b100);
        dt = 8'd2;
        tick(1);
        check("t5_on", o_cmd, 6'b011001);

        // Asynchronous reset mid-operation, then full dead time after release
        rst_n = 1'b0;
        #1;
        check("t6_rst_cmd", o_cmd, 6'b000000);
        check("t6_rst_fault", o_fault, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("t6_wait", o_cmd, 6'b000000);
        tick(1);
        check("t6_on", o_cmd, 6'b011001);

        // Directed sweep checked cycle by cycle against the model
        for (int i = 0; i < 10; i++) begin
            cmd = v_cmd[i];
            en  = v_en[i];
            dt  = v_dt[i];
            clr = (i % 2 == 1);
            tick(v_hold[i]);
        end
        clr = 1'b0;
        tick(2);
        running = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
